pipe_skid_reg: RTL
==================

# pipe_skid_reg

Parametrised pipeline-stage register, the generalised successor to the fixed inter-stage latches of the five-stage CPU. It carries NFIELD payload words of WIDTH bits between any two stages, using a valid/ready handshake instead of a bare write enable. It offers an optional two-entry skid buffer so that upstream ready is registered, and a synchronous flush that inserts an all-zero bubble (zero encodes nop). It also exposes occupancy and a saturating back-pressure counter for performance debug.

## Interface
- WIDTH, 32, bits per payload field
- NFIELD, 4, payload fields per entry (e.g. PC, Instr, ALUAns, DMRD)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNTW, 16, width of stall_cnt

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_data  in  NFIELD*WIDTH  upstream payload, field k at [k*WIDTH +: WIDTH]
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  NFIELD*WIDTH  main entry payload
- occupancy  out  2  held entries, 0..2 (0..1 when SKID=0)
- stall_cnt  out  CNTW  cycles with out_valid && !out_ready, saturating

## Operation
- Registers: main (data + valid), skid (data + valid, SKID=1 only). out_data is driven directly from main.
- Fires: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States (SKID=1): EMPTY, ONE, TWO.
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire && out_fire -> ONE, main <= in_data.
  - ONE, in_fire only -> TWO, skid <= in_data.
  - ONE, out_fire only -> EMPTY.
  - TWO: in_ready = 0; out_fire -> ONE, main <= skid, skid cleared.
- SKID=1: in_ready = !flush && state != TWO. The only combinational term is flush.
- SKID=0: in_ready = !flush && (!out_valid || out_ready). State is never TWO.
- Any register whose entry becomes invalid is written to zero, so out_data == 0 whenever out_valid == 0.
- Priority: reset > flush > handshake.
- flush:
  - state -> EMPTY; main and skid cleared to zero.
  - in_ready = 0 that cycle, so no transfer occurs and upstream must hold its entry or be flushed itself.
  - out_fire in a flush cycle is still a valid transfer for downstream. The stage drops its copy.
- occupancy = main.valid + skid.valid.
- stall_cnt:
  - Increments each cycle out_valid && !out_ready, including flush cycles.
  - Holds at 2^CNTW-1.
  - Cleared only by reset.

## Timing
- Reset values: out_valid 0, out_data 0, occupancy 0, stall_cnt 0. in_ready is 1 in the cycle after reset (SKID=1) and is 0 while reset is high.
- Latency: in_fire at edge N puts data on out_data/out_valid after edge N. It is visible in cycle N+1.
- Throughput: 1 entry/cycle when out_ready is held high, both modes.
- SKID=1 back-pressure:
  - out_ready falls while upstream streams: one extra entry is absorbed into skid.
  - in_ready falls the cycle after the state enters TWO.
- Reset mid-operation: all entries are dropped at the next edge regardless of flush or handshake.
- flush and in_valid in the same cycle: the entry is not accepted; the stage is EMPTY next cycle.

## Structure
- Package pipe_pkg holds:
  - state enum (EMPTY, ONE, TWO)
  - localparam NOP_WORD = '0
  - a helper localparam for payload width NFIELD*WIDTH
- One sub-module: sat_counter (parameter W, inputs inc/clr, output value), used for stall_cnt and reusable by the hazard unit.
- The skid path sits behind a generate on SKID.

## Test plan
- Stream with out_ready=1: stream 8 entries PC=0x3000+4k → out_data matches one cycle later, occupancy stays 1, stall_cnt=0.
- SKID=1 back-pressure: stream 0x3000, 0x3004, 0x3008, with out_ready=0 from cycle 2.
  - Required: occupancy reaches 2 and in_ready falls.
  - After out_ready=1: outputs appear in order 0x3000, 0x3004, 0x3008 with none lost.
  - stall_cnt equals the number of stalled cycles.
- Flush in TWO with in_valid=1: next cycle out_valid=0, out_data=0, occupancy=0; the offered entry is not accepted (in_ready=0 in the flush cycle).
- SKID=0 stall: out_ready=0 with main full → in_ready=0 in the same cycle, main held unchanged.
- Saturation: CNTW=4, out_ready held 0 for 20 cycles → stall_cnt sticks at 15. Reset mid-stall → every output at its reset value after the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline-stage register family.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } state_e;

  // Zero encodes a nop; cleared payloads are replicated from this bit.
  localparam bit NOP_WORD = 1'b0;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NFIELD = 4;
  localparam int unsigned PAYLOAD_W  = DEF_WIDTH * DEF_NFIELD;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      value_q <= '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush to a nop bubble, occupancy and a saturating stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NFIELD = 4,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNTW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NFIELD*WIDTH-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NFIELD*WIDTH-1:0]  out_data,
  output logic [1:0]               occupancy,
  output logic [CNTW-1:0]          stall_cnt
);

  localparam int unsigned PW = NFIELD * WIDTH;
  localparam logic [PW-1:0] Nop = {PW{NOP_WORD}};

  logic [PW-1:0] main_q, main_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid;
  logic          in_fire, out_fire;
  logic          stall_inc;

  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid_q && out_ready;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid};
  assign stall_inc = main_valid_q && !out_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_e        state_q, state_d;
      logic [PW-1:0] skid_q, skid_d;
      logic          skid_valid_q, skid_valid_d;

      // Registered ready: only flush (and reset) act combinationally.
      assign in_ready   = !reset && !flush && (state_q != StTwo);
      assign skid_valid = skid_valid_q;

      always_comb begin
        state_d      = state_q;
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        unique case (state_q)
          StEmpty: begin
            if (in_fire) begin
              main_d       = in_data;
              main_valid_d = 1'b1;
              state_d      = StOne;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              skid_d       = in_data;
              skid_valid_d = 1'b1;
              state_d      = StTwo;
            end else if (out_fire) begin
              main_d       = Nop;
              main_valid_d = 1'b0;
              state_d      = StEmpty;
            end
          end
          StTwo: begin
            if (out_fire) begin
              main_d       = skid_q;
              skid_d       = Nop;
              skid_valid_d = 1'b0;
              state_d      = StOne;
            end
          end
          default: state_d = StEmpty;
        endcase
        if (flush) begin
          state_d      = StEmpty;
          main_d       = Nop;
          main_valid_d = 1'b0;
          skid_d       = Nop;
          skid_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q      <= StEmpty;
          main_q       <= Nop;
          main_valid_q <= 1'b0;
          skid_q       <= Nop;
          skid_valid_q <= 1'b0;
        end else begin
          state_q      <= state_d;
          main_q       <= main_d;
          main_valid_q <= main_valid_d;
          skid_q       <= skid_d;
          skid_valid_q <= skid_valid_d;
        end
      end
    end else begin : g_single
      assign in_ready   = !flush && (!main_valid_q || out_ready);
      assign skid_valid = 1'b0;

      always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
          main_d       = Nop;
          main_valid_d = 1'b0;
        end else if (in_fire) begin
          main_d       = in_data;
          main_valid_d = 1'b1;
        end else if (out_fire) begin
          main_d       = Nop;
          main_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          main_q       <= Nop;
          main_valid_q <= 1'b0;
        end else begin
          main_q       <= main_d;
          main_valid_q <= main_valid_d;
        end
      end
    end
  endgenerate

  sat_counter #(
    .W(CNTW)
  ) u_stall_cnt (
    .clk  (clk),
    .inc  (stall_inc),
    .clr  (reset),
    .value(stall_cnt)
  );

endmodule
